// File: rtl/gate_window_pkg.sv
// Shared types and the bitwise window-reduction helper for gate_window_unit and
// its combinational logic-op ALU.
package gate_window_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_PASS_A = 3'd6,
    OP_NOT_A  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    RED_AND  = 2'd0,
    RED_OR   = 2'd1,
    RED_XOR  = 2'd2,
    RED_RSVD = 2'd3
  } red_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Folds one result bit into one accumulator bit; the reserved code acts as OR.
  function automatic logic red_apply(input logic acc, input logic r, input red_e red);
    case (red)
      RED_AND: return acc & r;
      RED_XOR: return acc ^ r;
      default: return acc | r;
    endcase
  endfunction

endpackage

// File: rtl/gate_op_alu.sv
// Purely combinational WIDTH-bit, 8-operation bitwise logic unit.
module gate_op_alu
  import gate_window_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r
);

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    r = '0;
    case (op_e'(op))
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NAND:   r = ~(a & b);
      OP_NOR:    r = ~(a | b);
      OP_XNOR:   r = ~(a ^ b);
      OP_PASS_A: r = a;
      OP_NOT_A:  r = ~a;
      default:   r = '0;
    endcase
  end

endmodule

// File: rtl/gate_window_unit.sv
// Bitwise logic unit with per-sample and WINDOW-sample accumulate modes.
// Optional out_parity port is enabled by defining GATE_WINDOW_PARITY_EN.
module gate_window_unit
  import gate_window_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 4,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic [1:0]       red,
  input  logic             mode,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
`ifdef GATE_WINDOW_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  red_e             red_q, red_d;

  logic [2:0]       alu_op;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] fold;
  logic             emit;
  logic [WIDTH-1:0] emit_data;
  logic [CNT_W-1:0] emit_cnt;

  // Inside a window the op latched with the first sample is used, not the live input.
  assign alu_op = (state_q == ACCUM) ? op_q : op;

  gate_op_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (in_a),
    .b  (in_b),
    .op (alu_op),
    .r  (r)
  );

  always_comb begin
    fold = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fold[i] = red_apply(acc_q[i], r[i], red_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    op_d      = op_q;
    red_d     = red_q;
    emit      = 1'b0;
    emit_data = out_data;
    emit_cnt  = out_count;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!mode) begin
            emit      = 1'b1;
            emit_data = r;
            emit_cnt  = CNT_W'(1);
          end else begin
            op_d    = op;
            red_d   = red_e'(red);
            acc_d   = r;
            cnt_d   = CNT_W'(1);
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (in_valid) begin
          acc_d = fold;
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A sample arriving with flush is folded in before the partial window is emitted.
        if ((in_valid && (cnt_d == CNT_W'(WINDOW))) || flush) begin
          emit      = 1'b1;
          emit_data = acc_d;
          emit_cnt  = cnt_d;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      red_q     <= RED_AND;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      red_q     <= red_d;
      out_valid <= emit;
      out_data  <= emit_data;
      out_count <= emit_cnt;
    end
  end

`ifdef GATE_WINDOW_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (emit) begin
      out_parity <= ^emit_data;
    end
  end
`endif

endmodule
